// File: rtl/ex_redirect_controller_if.sv
// EX-stage redirect bundle: the resolved control-flow inputs seen by the
// redirect controller and the redirect it returns to the front end.
//
// Handshake: REDIRECT_VALID qualifies REDIRECT_PC for exactly one advancing
// cycle (CACHE_READY=1). There is no back-pressure. While CACHE_READY=0 the
// pulse is frozen together with the rest of the pipeline, so a consumer
// that also advances only on CACHE_READY sees it exactly once.
interface ex_redirect_controller_if;
   logic        EX_VALID;
   logic        EX_JUMP;
   logic [31:0] EX_TARGET;
   logic [31:0] EX_PC;
   logic [31:0] PRED_PC;
   logic        PREDICTED;
   logic        REDIRECT_VALID;
   logic [31:0] REDIRECT_PC;

   // EX datapath / fetch side
   modport master (
      output EX_VALID, EX_JUMP, EX_TARGET, EX_PC, PRED_PC,
      input  PREDICTED, REDIRECT_VALID, REDIRECT_PC
   );

   // redirect controller side
   modport slave (
      input  EX_VALID, EX_JUMP, EX_TARGET, EX_PC, PRED_PC,
      output PREDICTED, REDIRECT_VALID, REDIRECT_PC
   );
endinterface

// File: rtl/ex_redirect_controller.sv
// Redirect and flush sequencer beside the EX stage. It compares the PC
// already fetched into ID/FB with the resolved successor. On a mismatch it
// issues a one-cycle redirect, then runs timed front-end and EX flush
// windows. It also keeps branch and mispredict counters.
module ex_redirect_controller #(
   parameter int unsigned FLUSH_FE_CYCLES = 4,
   parameter int unsigned FLUSH_EX_CYCLES = 6,
   parameter int unsigned WARMUP_CYCLES   = 3,
   parameter int unsigned PERF_WIDTH      = 32
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    CACHE_READY,
   input  logic                    COUNT_CLEAR,
   ex_redirect_controller_if.slave ex_if,
   output logic                    FLUSH_FE,
   output logic                    FLUSH_EX,
   output logic [PERF_WIDTH-1:0]   BRANCH_COUNT,
   output logic [PERF_WIDTH-1:0]   MISPREDICT_COUNT,
   output logic [1:0]              STATE_DBG
);

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_IDLE   = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   localparam logic [2:0] WARM_LAST = 3'(WARMUP_CYCLES);
   localparam logic [3:0] FE_LAST   = 4'(FLUSH_FE_CYCLES);
   localparam logic [3:0] EX_LAST   = 4'(FLUSH_EX_CYCLES);

   state_t      state_q, state_d;
   logic [2:0]  warm_q, warm_d;
   logic [3:0]  fcnt_q, fcnt_d;
   logic        fe_q, fe_d;
   logic        ex_q, ex_d;
   logic        rv_q, rv_d;
   logic [31:0] rpc_q, rpc_d;
   logic [PERF_WIDTH-1:0] br_q, mis_q;

   logic        jchk, schk, mis;
   logic [31:0] expected_pc;

   // Successor check: jumps are checked in WARMUP and IDLE; fall-through
   // checks wait until warm-up has finished. A jump overrides EX_VALID.
   always_comb begin
      jchk        = (state_q != ST_FLUSH) & ex_if.EX_JUMP;
      schk        = ex_if.EX_VALID & ~ex_if.EX_JUMP & (state_q == ST_IDLE);
      expected_pc = ex_if.EX_JUMP ? ex_if.EX_TARGET : (ex_if.EX_PC + 32'd4);
      mis         = (jchk | schk) & (ex_if.PRED_PC != expected_pc);
   end

   // Next-state and next-output logic for the redirect/flush sequencer.
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      fcnt_d  = fcnt_q;
      fe_d    = fe_q;
      ex_d    = ex_q;
      rv_d    = 1'b0;
      rpc_d   = rpc_q;
      case (state_q)
         ST_WARMUP, ST_IDLE: begin
            if (mis) begin
               // A mispredict also ends warm-up: the flush returns to IDLE.
               state_d = ST_FLUSH;
               fcnt_d  = 4'd1;
               fe_d    = 1'b1;
               ex_d    = 1'b1;
               rv_d    = 1'b1;
               rpc_d   = expected_pc;
            end else if (state_q == ST_WARMUP) begin
               warm_d = warm_q + 3'd1;
               if (warm_d == WARM_LAST) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FLUSH: begin
            // fcnt_q is the number of cycles the flush has already been high.
            fcnt_d = fcnt_q + 4'd1;
            if (fcnt_q >= FE_LAST) begin
               fe_d = 1'b0;
            end
            if (fcnt_q >= EX_LAST) begin
               ex_d    = 1'b0;
               fcnt_d  = 4'd0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_WARMUP;
      endcase
   end

   // Sequencer registers; everything holds while the cache stalls.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_WARMUP;
         warm_q  <= 3'd0;
         fcnt_q  <= 4'd0;
         fe_q    <= 1'b0;
         ex_q    <= 1'b0;
         rv_q    <= 1'b0;
         rpc_q   <= 32'd0;
      end else if (CACHE_READY) begin
         state_q <= state_d;
         warm_q  <= warm_d;
         fcnt_q  <= fcnt_d;
         fe_q    <= fe_d;
         ex_q    <= ex_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
      end
   end

   // Performance counters; a clear beats an increment on the same edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         br_q  <= '0;
         mis_q <= '0;
      end else if (CACHE_READY) begin
         if (COUNT_CLEAR) begin
            br_q  <= '0;
            mis_q <= '0;
         end else begin
            if (jchk) br_q  <= br_q + PERF_WIDTH'(1);
            if (mis)  mis_q <= mis_q + PERF_WIDTH'(1);
         end
      end
   end

   assign ex_if.PREDICTED      = ~(mis & CACHE_READY);
   assign ex_if.REDIRECT_VALID = rv_q;
   assign ex_if.REDIRECT_PC    = rpc_q;
   assign FLUSH_FE             = fe_q;
   assign FLUSH_EX             = ex_q;
   assign BRANCH_COUNT         = br_q;
   assign MISPREDICT_COUNT     = mis_q;
   assign STATE_DBG            = state_q;

endmodule

// File: tb/tb_ex_redirect_controller.sv
// Bench for ex_redirect_controller. The counters are built 4 bits wide so
// that the wrap from 15 to 0 is reachable in a short run.
module tb_ex_redirect_controller;

   localparam int PW = 4;

   logic          CLK;
   logic          RST_N;
   logic          CACHE_READY;
   logic          COUNT_CLEAR;
   logic          FLUSH_FE;
   logic          FLUSH_EX;
   logic [PW-1:0] BRANCH_COUNT;
   logic [PW-1:0] MISPREDICT_COUNT;
   logic [1:0]    STATE_DBG;

   ex_redirect_controller_if ex_if ();

   ex_redirect_controller #(
      .FLUSH_FE_CYCLES (4),
      .FLUSH_EX_CYCLES (6),
      .WARMUP_CYCLES   (3),
      .PERF_WIDTH      (PW)
   ) dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .CACHE_READY      (CACHE_READY),
      .COUNT_CLEAR      (COUNT_CLEAR),
      .ex_if            (ex_if),
      .FLUSH_FE         (FLUSH_FE),
      .FLUSH_EX         (FLUSH_EX),
      .BRANCH_COUNT     (BRANCH_COUNT),
      .MISPREDICT_COUNT (MISPREDICT_COUNT),
      .STATE_DBG        (STATE_DBG)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0]   exp_q[$];
   logic [PW-1:0] exp_br  = '0;
   logic [PW-1:0] exp_mis = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ex_if.EX_VALID  = 1'b0;
      ex_if.EX_JUMP   = 1'b0;
      ex_if.EX_TARGET = 32'd0;
      ex_if.EX_PC     = 32'd0;
      ex_if.PRED_PC   = 32'd0;
      COUNT_CLEAR     = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_branch"}, 32'(BRANCH_COUNT), 32'(exp_br));
      check({tag, "_mispredict"}, 32'(MISPREDICT_COUNT), 32'(exp_mis));
   endtask

   // ---------------- driver tasks ----------------
   // Correctly predicted check in IDLE. EX_VALID is set even for jumps, so
   // the jump target must win over EX_PC+4.
   task automatic drive_match(input logic jump, input logic [31:0] val);
      logic [31:0] succ;
      ex_if.EX_VALID = 1'b1;
      ex_if.EX_JUMP  = jump;
      if (jump) begin
         ex_if.EX_TARGET = val;
         ex_if.EX_PC     = $urandom & 32'hFFFF_FFFC;
         succ            = val;
      end else begin
         ex_if.EX_PC     = val;
         ex_if.EX_TARGET = $urandom;
         succ            = val + 32'd4;
      end
      ex_if.PRED_PC = succ;
      #1;
      check("match_predicted", 32'(ex_if.PREDICTED), 32'd1);
      if (jump) exp_br++;
      step();
      clear_inputs();
      check("match_no_flush", 32'(FLUSH_EX), 32'd0);
      check("match_no_redirect", 32'(ex_if.REDIRECT_VALID), 32'd0);
      check_counts("match");
   endtask

   // Mispredicting check; the correct successor goes onto the scoreboard.
   task automatic drive_mispredict(input logic jump, input logic [31:0] val,
                                   input logic [31:0] pred_xor, input logic clr);
      logic [31:0] succ;
      ex_if.EX_JUMP = jump;
      if (jump) begin
         ex_if.EX_VALID  = 1'($urandom_range(0, 1));
         ex_if.EX_TARGET = val;
         ex_if.EX_PC     = $urandom & 32'hFFFF_FFFC;
         succ            = val;
      end else begin
         ex_if.EX_VALID  = 1'b1;
         ex_if.EX_PC     = val;
         ex_if.EX_TARGET = $urandom;
         succ            = val + 32'd4;
      end
      ex_if.PRED_PC = succ ^ pred_xor;
      COUNT_CLEAR   = clr;
      #1;
      check("mis_predicted", 32'(ex_if.PREDICTED), 32'd0);
      exp_q.push_back(succ);
      if (clr) begin
         exp_br  = '0;
         exp_mis = '0;
      end else begin
         exp_mis++;
         if (jump) exp_br++;
      end
      step();
      clear_inputs();
      check("mis_redirect_valid", 32'(ex_if.REDIRECT_VALID), 32'd1);
      check("mis_flush_fe", 32'(FLUSH_FE), 32'd1);
      check("mis_flush_ex", 32'(FLUSH_EX), 32'd1);
      check("mis_state", 32'(STATE_DBG), 32'd2);
      check_counts("mis");
   endtask

   // Walk a flush window that has just started, counting ready cycles with
   // each flush high. Optionally stall 5 cycles at freeze_at and/or drive
   // mismatching jumps every cycle.
   task automatic run_flush(input int freeze_at, input logic noisy);
      int fe_hi = 0;
      int ex_hi = 0;
      int cyc   = 0;
      logic hold_fe, hold_ex, hold_rv;
      while (FLUSH_EX && cyc < 40) begin
         if (cyc == freeze_at) begin
            hold_fe = FLUSH_FE;
            hold_ex = FLUSH_EX;
            hold_rv = ex_if.REDIRECT_VALID;
            CACHE_READY = 1'b0;
            repeat (5) step();
            check("freeze_fe", 32'(FLUSH_FE), 32'(hold_fe));
            check("freeze_ex", 32'(FLUSH_EX), 32'(hold_ex));
            check("freeze_rv", 32'(ex_if.REDIRECT_VALID), 32'(hold_rv));
            CACHE_READY = 1'b1;
         end
         if (cyc == 0) check("rv_first", 32'(ex_if.REDIRECT_VALID), 32'd1);
         if (cyc == 1) check("rv_cleared", 32'(ex_if.REDIRECT_VALID), 32'd0);
         if (noisy) begin
            ex_if.EX_JUMP   = 1'b1;
            ex_if.EX_VALID  = 1'b1;
            ex_if.EX_TARGET = $urandom;
            ex_if.PRED_PC   = ex_if.EX_TARGET ^ 32'h10;
            #1;
            check("flush_predicted", 32'(ex_if.PREDICTED), 32'd1);
         end
         if (FLUSH_FE) fe_hi++;
         if (FLUSH_EX) ex_hi++;
         step();
         cyc++;
      end
      clear_inputs();
      check("flush_fe_len", 32'(fe_hi), 32'd4);
      check("flush_ex_len", 32'(ex_hi), 32'd6);
      check("flush_done_ex", 32'(FLUSH_EX), 32'd0);
      check("flush_state_idle", 32'(STATE_DBG), 32'd1);
      check_counts("flush");
   endtask

   // ---------------- scoreboard ----------------
   logic rv_prev = 1'b0;
   always @(negedge CLK) begin
      if (ex_if.REDIRECT_VALID && !rv_prev) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_redirect", 32'd1, 32'd0);
         end else begin
            check("sb_redirect_pc", ex_if.REDIRECT_PC, exp_q.pop_front());
         end
      end
      rv_prev = ex_if.REDIRECT_VALID;
   end

   // ---------------- stimulus ----------------
   initial begin
      RST_N       = 1'b0;
      CACHE_READY = 1'b0;
      clear_inputs();
      repeat (2) step();
      check("rst_flush_fe", 32'(FLUSH_FE), 32'd0);
      check("rst_flush_ex", 32'(FLUSH_EX), 32'd0);
      check("rst_rv", 32'(ex_if.REDIRECT_VALID), 32'd0);
      check("rst_rpc", ex_if.REDIRECT_PC, 32'd0);
      check("rst_state", 32'(STATE_DBG), 32'd0);
      check_counts("rst");

      // Warm-up: fall-through mismatches are ignored for 3 ready cycles.
      RST_N       = 1'b1;
      CACHE_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_if.EX_VALID = 1'b1;
         ex_if.EX_PC    = 32'h100;
         ex_if.PRED_PC  = 32'h200;
         #1;
         check("warm_predicted", 32'(ex_if.PREDICTED), 32'd1);
         step();
         check("warm_no_flush", 32'(FLUSH_EX), 32'd0);
      end
      check("warm_done_state", 32'(STATE_DBG), 32'd1);
      drive_mispredict(1'b0, 32'h100, 32'h304, 1'b0);   // PRED_PC 0x200 vs 0x104
      run_flush(0, 1'b0);

      // Jump checks in IDLE.
      drive_match(1'b1, 32'h400);
      drive_mispredict(1'b1, 32'h400, 32'h4, 1'b0);
      run_flush(2, 1'b1);

      // First IDLE cycle starts a new flush; fall-through wraps to 0.
      drive_mispredict(1'b0, 32'hFFFF_FFFC, 32'h8, 1'b0);
      run_flush(-1, 1'b0);
      drive_match(1'b0, 32'hFFFF_FFFC);
      drive_match(1'b1, 32'h800);

      // Push the mispredict counter through 15 -> 0.
      for (int i = 0; i < 13; i++) begin
         drive_mispredict(1'(i % 2), $urandom & 32'hFFFF_FFFC, 32'h40, 1'b0);
         run_flush(-1, 1'(i == 3));
      end

      // Clear wins over the increment on the same edge.
      drive_mispredict(1'b1, 32'h1234, 32'h100, 1'b1);
      run_flush(-1, 1'b0);

      // Asynchronous reset in the middle of a flush.
      drive_mispredict(1'b1, 32'h5000, 32'h4, 1'b0);
      step();
      RST_N = 1'b0;
      #1;
      exp_br  = '0;
      exp_mis = '0;
      check("arst_flush_fe", 32'(FLUSH_FE), 32'd0);
      check("arst_flush_ex", 32'(FLUSH_EX), 32'd0);
      check("arst_rv", 32'(ex_if.REDIRECT_VALID), 32'd0);
      check("arst_rpc", ex_if.REDIRECT_PC, 32'd0);
      check("arst_state", 32'(STATE_DBG), 32'd0);
      check_counts("arst");
      step();
      RST_N = 1'b1;

      // After reset: fall-through suppressed, jump mispredict ends warm-up.
      ex_if.EX_VALID = 1'b1;
      ex_if.EX_PC    = 32'h900;
      ex_if.PRED_PC  = 32'h0;
      #1;
      check("rewarm_predicted", 32'(ex_if.PREDICTED), 32'd1);
      step();
      clear_inputs();
      drive_mispredict(1'b1, 32'hA00, 32'h4, 1'b0);
      run_flush(-1, 1'b0);
      ex_if.EX_VALID = 1'b1;
      ex_if.EX_PC    = 32'h900;
      ex_if.PRED_PC  = 32'h0;
      #1;
      check("rewarm_fallthrough_live", 32'(ex_if.PREDICTED), 32'd0);
      clear_inputs();
      step();

      check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_redirect_controller.md
Name: ex_redirect_controller

Overview:
- Owns control-flow redirect and flush sequencing for the 5-stage pipeline. It sits beside the EX stage datapath.
- Each cycle it compares the PC already fetched into ID/FB against the architecturally correct successor resolved in EX: the jump target when taken, otherwise EX_PC+4.
- On mismatch it issues a redirect and runs timed flush windows for the front end and for EX. It also keeps branch and mispredict performance counters.

Parameters:
FLUSH_FE_CYCLES, 4, number of cycles FLUSH_FE stays high per mispredict (legal 1..15)
FLUSH_EX_CYCLES, 6, number of cycles FLUSH_EX stays high per mispredict (legal FLUSH_FE_CYCLES..15)
WARMUP_CYCLES, 3, CACHE_READY-qualified cycles after reset before fall-through checks are enabled (legal 1..7)
PERF_WIDTH, 32, width of the performance counters

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
CACHE_READY  input  1  global advance enable; when 0, all state holds
EX_VALID  input  1  valid non-jump instruction occupies EX (fall-through check request)
EX_JUMP  input  1  EX resolved a taken branch, JAL or JALR
EX_TARGET  input  32  resolved jump target
EX_PC  input  32  PC of the instruction in EX
PRED_PC  input  32  PC currently held in ID/FB
COUNT_CLEAR  input  1  synchronous clear of the perf counters
PREDICTED  output  1  combinational; 0 when the current check mismatches
FLUSH_FE  output  1  registered front-end flush
FLUSH_EX  output  1  registered EX-kill; downstream gates WB data, cache control and jump outputs with it
REDIRECT_VALID  output  1  registered one-cycle redirect pulse
REDIRECT_PC  output  32  registered correct fetch address
BRANCH_COUNT  output  PERF_WIDTH  count of taken-jump checks
MISPREDICT_COUNT  output  PERF_WIDTH  count of mismatching checks

Behaviour:
- Reset (async, RST_N=0):
  - State is WARMUP with warm counter 0.
  - FLUSH_FE=0, FLUSH_EX=0, REDIRECT_VALID=0, REDIRECT_PC=0, both perf counters 0, flush counter 0.
  - Reset mid-flush aborts the flush immediately.
- Freeze: while CACHE_READY=0, every register holds, including REDIRECT_VALID. All counters advance only on cycles with CACHE_READY=1.
- Check definition, evaluated combinationally in states WARMUP and IDLE only:
  - jchk = EX_JUMP. expected = EX_TARGET.
  - schk = EX_VALID & !EX_JUMP & (state==IDLE). expected = EX_PC+4, 32-bit modulo (0xFFFFFFFC+4 = 0).
  - chk = jchk | schk. mis = chk & (PRED_PC != expected).
- PREDICTED = !(mis & CACHE_READY). It is 1 in FLUSH state regardless of inputs.
- States:
  - WARMUP:
    - The warm counter increments on each CACHE_READY cycle; move to IDLE when it reaches WARMUP_CYCLES.
    - Jump checks are active; fall-through checks are suppressed.
    - A mispredict takes priority and goes directly to FLUSH; the warm-up is then considered complete.
  - IDLE: on mis (with CACHE_READY), go to FLUSH.
  - FLUSH:
    - EX_* inputs are ignored, so no checks and no counting.
    - The flush counter increments each CACHE_READY cycle.
    - FLUSH_FE deasserts after FLUSH_FE_CYCLES cycles high; FLUSH_EX deasserts after FLUSH_EX_CYCLES cycles high.
    - The state returns to IDLE on the same edge that FLUSH_EX drops.
- Mispredict edge (latency 1): at the next rising edge the block sets
  - REDIRECT_VALID=1 and REDIRECT_PC=expected,
  - FLUSH_FE=1 and FLUSH_EX=1,
  - flush counter = 1.
- REDIRECT_VALID clears on the following CACHE_READY edge.
- Back-to-back: the first cycle back in IDLE may start a new flush; FLUSH_EX then shows no gap.
- Perf counters:
  - BRANCH_COUNT increments on jchk with CACHE_READY, outside FLUSH.
  - MISPREDICT_COUNT increments on mis with CACHE_READY.
  - Both wrap modulo 2^PERF_WIDTH.
  - COUNT_CLEAR takes priority over increment on the same edge.
- Simultaneous EX_VALID and EX_JUMP: the jump check wins and EX_VALID is ignored.

Test Plan:
- Reset, then 3 CACHE_READY cycles with EX_VALID=1, EX_PC=0x100, PRED_PC=0x200 -> PREDICTED stays 1, no flush (WARMUP). 4th cycle -> PREDICTED=0; next edge REDIRECT_PC=0x104, REDIRECT_VALID=1 for 1 cycle, FLUSH_FE high 4 cycles, FLUSH_EX high 6 cycles, MISPREDICT_COUNT=1.
- In IDLE: EX_JUMP=1, EX_TARGET=0x400, PRED_PC=0x400 -> no flush, PREDICTED=1, BRANCH_COUNT=1. Repeat with PRED_PC=0x404 -> redirect to 0x400, both counters increment.
- Mispredict issued, then CACHE_READY=0 for 5 cycles mid-flush -> FLUSH_FE, FLUSH_EX and REDIRECT_VALID hold their values. After resume, the total high time still equals 4 and 6 ready cycles.
- During FLUSH, drive EX_JUMP=1 with a mismatching target every cycle -> no new redirect, counters unchanged, PREDICTED=1.
- Assert RST_N=0 asynchronously while FLUSH_EX=1 -> all outputs are 0 before the next clock edge, and the state is WARMUP.
- Preload counters to all-ones via repeated mispredicts in a PERF_WIDTH=4 build -> wraps 15 to 0. COUNT_CLEAR together with a mispredict -> counter reads 0.
